// File: rtl/array_controller.sv
// Control FSM for the systolic-array datapath: fill the operand buffer from AXIS,
// stream it into the array, present the result on AXIS, then clear for the next job.
module array_controller (
    input  logic i_clk,
    input  logic i_rst,
    input  logic s_axis_valid,
    output logic s_axis_ready,
    input  logic m_axis_ready,
    output logic m_axis_valid,
    input  logic buff_is_empty,
    input  logic buff_is_full,
    output logic buff_rst_n,
    output logic buff_rd,
    output logic buff_wr,
    input  logic arr_C_valid,
    output logic arr_rst_n
);

    typedef enum logic [2:0] {
        ST_WAIT    = 3'd0,
        ST_FILL    = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_OUTPUT  = 3'd3,
        ST_CLEAR   = 3'd4
    } state_e;

    state_e state_q;
    state_e state_d;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        s_axis_ready = 1'b0;
        m_axis_valid = 1'b0;
        buff_rst_n   = 1'b1;
        buff_rd      = 1'b0;
        buff_wr      = 1'b0;
        arr_rst_n    = 1'b0;

        unique case (state_q)
            ST_WAIT: begin
                // A full buffer at job start is stale and must be flushed first.
                if (buff_is_full) begin
                    state_d = ST_CLEAR;
                end else if (s_axis_valid) begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                s_axis_ready = !buff_is_full;
                buff_wr      = s_axis_valid && !buff_is_full;
                if (buff_is_full) begin
                    state_d = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                arr_rst_n = 1'b1;
                buff_rd   = !buff_is_empty;
                if (buff_is_empty && arr_C_valid) begin
                    state_d = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                m_axis_valid = 1'b1;
                arr_rst_n    = 1'b1;
                if (m_axis_ready) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                buff_rst_n = 1'b0;
                state_d    = ST_WAIT;
            end
            default: begin
                state_d = ST_WAIT;
            end
        endcase

        // Outputs follow reset immediately, not at the next edge.
        if (i_rst) begin
            s_axis_ready = 1'b0;
            m_axis_valid = 1'b0;
            buff_rd      = 1'b0;
            buff_wr      = 1'b0;
            buff_rst_n   = 1'b0;
            arr_rst_n    = 1'b0;
        end
    end

endmodule

// File: tb/tb_array_controller.sv
// Self-checking bench for array_controller: directed phase walk, then random
// inputs against a job-phase reference model.
module tb_array_controller;

    logic clk = 1'b0;
    logic rst, sv, sr, mr, mv, empty, full, brst, rd, wr, cv, arst;

    int n_cmp = 0;
    int n_bad = 0;

    localparam int P_IDLE    = 0;
    localparam int P_LOAD    = 1;
    localparam int P_CRUNCH  = 2;
    localparam int P_PRESENT = 3;
    localparam int P_FLUSH   = 4;

    int mphase;

    always #5 clk = ~clk;

    array_controller dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .s_axis_valid (sv),
        .s_axis_ready (sr),
        .m_axis_ready (mr),
        .m_axis_valid (mv),
        .buff_is_empty(empty),
        .buff_is_full (full),
        .buff_rst_n   (brst),
        .buff_rd      (rd),
        .buff_wr      (wr),
        .arr_C_valid  (cv),
        .arr_rst_n    (arst)
    );

    // Job progression as described by the phase rules.
    function automatic int next_phase(input int p);
        int n;
        n = p;
        if (p == P_IDLE)         n = full ? P_FLUSH : (sv ? P_LOAD : P_IDLE);
        else if (p == P_LOAD)    n = full ? P_CRUNCH : P_LOAD;
        else if (p == P_CRUNCH)  n = (empty && cv) ? P_PRESENT : P_CRUNCH;
        else if (p == P_PRESENT) n = mr ? P_FLUSH : P_PRESENT;
        else                     n = P_IDLE;
        return n;
    endfunction

    // Expected {s_axis_ready, m_axis_valid, buff_rst_n, buff_rd, buff_wr, arr_rst_n}.
    function automatic logic [5:0] exp_out(input int p);
        logic a_rdy, m_vld, b_clr_n, b_rd, b_wr, a_clr_n;
        a_rdy = 1'b0; m_vld = 1'b0; b_clr_n = 1'b1; b_rd = 1'b0; b_wr = 1'b0; a_clr_n = 1'b0;
        if (rst) begin
            b_clr_n = 1'b0;
        end else if (p == P_LOAD) begin
            a_rdy = !full;
            b_wr  = sv && !full;
        end else if (p == P_CRUNCH) begin
            b_rd    = !empty;
            a_clr_n = 1'b1;
        end else if (p == P_PRESENT) begin
            m_vld   = 1'b1;
            a_clr_n = 1'b1;
        end else if (p == P_FLUSH) begin
            b_clr_n = 1'b0;
        end
        return {a_rdy, m_vld, b_clr_n, b_rd, b_wr, a_clr_n};
    endfunction

    task automatic check(input string tag);
        logic [5:0] obs;
        logic [5:0] exp;
        obs = {sr, mv, brst, rd, wr, arst};
        exp = exp_out(mphase);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b (phase %0d)", tag, obs, exp, mphase);
        end
        n_cmp++;
        assert (!(wr && rd) && !(wr && full) && !(rd && empty)) else begin
            n_bad++;
            $error("FAIL %s_strobe_rule: observed wr=%b rd=%b full=%b empty=%b expected legal strobes",
                   tag, wr, rd, full, empty);
        end
    endtask

    task automatic set_in(input logic v, input logic f, input logic e, input logic c, input logic r);
        sv = v; full = f; empty = e; cv = c; mr = r;
    endtask

    // Check combinational response to the current inputs, clock, then check the new phase.
    task automatic step(input string tag);
        if (rst) mphase = P_IDLE;
        #1;
        check({tag, "_pre"});
        @(posedge clk);
        if (rst) mphase = P_IDLE;
        else     mphase = next_phase(mphase);
        #1;
        check({tag, "_post"});
    endtask

    initial begin
        rst = 1'b1;
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        mphase = P_IDLE;

        // Reset held for three edges.
        for (int i = 0; i < 3; i++) step("reset_hold");
        rst = 1'b0;
        #1;
        check("after_release");

        // Stale full buffer wins over s_axis_valid.
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step("wait_full_to_clear");
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("clear_to_wait");

        // Fill handshake.
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step("wait_to_fill");
        step("fill_write");
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("fill_idle");
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step("fill_full_to_compute");

        // Compute: early arr_C_valid ignored while data remains.
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("compute_read");
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("compute_early_cvalid");
        step("compute_early_cvalid2");
        set_in(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step("compute_to_output");

        // Output back-pressure then handshake.
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step("output_hold");
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step("output_handshake");
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("clear_done");

        // Asynchronous reset mid-FILL.
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step("wait_to_fill2");
        step("fill2");
        #3;
        rst = 1'b1;
        mphase = P_IDLE;
        #1;
        check("async_reset_mid_fill");
        step("reset_mid_hold");
        rst = 1'b0;
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("after_mid_reset");

        // Random inputs against the model, with occasional reset pulses.
        for (int i = 0; i < 3000; i++) begin
            logic f, e;
            f = ($urandom_range(0, 5) == 0);
            e = f ? 1'b0 : ($urandom_range(0, 2) == 0);
            set_in(1'($urandom_range(0, 1)), f, e,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            rst = ($urandom_range(0, 199) == 0);
            step("random");
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
